// File: rtl/fetch_unit_if.sv
// Bus between the fetch stage and its neighbours: stall feedback in, program
// memory port and the fetched instruction register out.
interface fetch_unit_if #(
  parameter int PC_W = 8
);
  logic            stall;
  logic            stall_pm;
  logic [23:0]     pm_data;
  logic [PC_W-1:0] pm_addr;
  logic [PC_W-1:0] pc;
  logic [23:0]     ins;
  logic            ins_valid;
  logic            halted;

  modport master (
    input  stall, stall_pm, pm_data,
    output pm_addr, pc, ins, ins_valid, halted
  );

  modport slave (
    output stall, stall_pm, pm_data,
    input  pm_addr, pc, ins, ins_valid, halted
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, instruction register, JUMP redirect and HLT halt.
// Define FETCH_PERF_EN to add the saturating stall_cnt output.
module fetch_unit #(
  parameter int          PC_W     = 8,
  parameter logic [23:0] NOP_WORD = 24'h000000
) (
  input  logic        clk,
  input  logic        reset,
  fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  typedef enum logic {RUN, HALT} state_t;

  localparam logic [4:0] OP_HLT = 5'b10001;

  state_t          state_reg, state_next;
  logic [PC_W-1:0] pc_reg, pc_next;
  logic [23:0]     ins_reg, ins_next;
  logic            ins_valid_reg, ins_valid_next;
  logic            halted_reg, halted_next;
  logic            jt_reg, jt_next;

  logic            is_hlt;
  logic            is_jump;
  logic [PC_W-1:0] jump_target;

  assign is_hlt      = (ins_reg[23:19] == OP_HLT);
  assign is_jump     = (ins_reg[23:21] == 3'b111);
  assign jump_target = ins_reg[PC_W-1:0];

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    ins_next       = ins_reg;
    ins_valid_next = ins_valid_reg;
    halted_next    = halted_reg;
    jt_next        = jt_reg;
    case (state_reg)
      RUN: begin
        if (is_hlt) begin
          state_next  = HALT;
          halted_next = 1'b1;
        end else if (is_jump && !jt_reg) begin
          // The redirect wins over any stall so a jump is never lost.
          pc_next        = jump_target;
          ins_next       = NOP_WORD;
          ins_valid_next = 1'b0;
          jt_next        = 1'b1;
        end else if (bus.stall_pm) begin
          ins_next       = NOP_WORD;
          ins_valid_next = 1'b0;
        end else if (!bus.stall) begin
          ins_next       = bus.pm_data;
          ins_valid_next = 1'b1;
          pc_next        = pc_reg + {{(PC_W-1){1'b0}}, 1'b1};
          jt_next        = 1'b0;
        end
      end
      HALT: begin
        state_next = HALT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= RUN;
      pc_reg        <= '0;
      ins_reg       <= NOP_WORD;
      ins_valid_reg <= 1'b0;
      halted_reg    <= 1'b0;
      jt_reg        <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      ins_reg       <= ins_next;
      ins_valid_reg <= ins_valid_next;
      halted_reg    <= halted_next;
      jt_reg        <= jt_next;
    end
  end

`ifdef FETCH_PERF_EN
  logic        count_stall;
  logic [15:0] stall_cnt_reg, stall_cnt_next;

  // Counts only the bubble and hold cycles, never halt or jump cycles.
  assign count_stall = (state_reg == RUN) && !is_hlt && !(is_jump && !jt_reg) &&
                       (bus.stall_pm || bus.stall);

  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    if (count_stall && (stall_cnt_reg != 16'hFFFF))
      stall_cnt_next = stall_cnt_reg + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_cnt_reg <= '0;
    else        stall_cnt_reg <= stall_cnt_next;
  end

  assign stall_cnt = stall_cnt_reg;
`endif

  assign bus.pm_addr   = pc_reg;
  assign bus.pc        = pc_reg;
  assign bus.ins       = ins_reg;
  assign bus.ins_valid = ins_valid_reg;
  assign bus.halted    = halted_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes the expected post-edge state,
// a negedge monitor pops and compares.
module tb_fetch_unit;

  logic clk;
  logic reset;
  logic [23:0] mem [256];
  int checks;
  int errors;
  int cyc;

  fetch_unit_if #(.PC_W(8)) bus ();

`ifdef FETCH_PERF_EN
  logic [15:0] stall_cnt;
`endif

  fetch_unit #(.PC_W(8), .NOP_WORD(24'h000000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef FETCH_PERF_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  assign bus.pm_data = mem[bus.pm_addr];

  typedef struct {
    int          cyc;
    string       name;
    logic [7:0]  pc;
    logic [23:0] ins;
    logic        v;
    logic        h;
  } sb_t;

  sb_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares every entry whose target edge has already happened.
  always @(negedge clk) begin
    sb_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      checks++;
      if (bus.pc !== e.pc || bus.ins !== e.ins || bus.ins_valid !== e.v || bus.halted !== e.h) begin
        errors++;
        $display("FAIL %s: got pc=%h ins=%h v=%b h=%b, expected pc=%h ins=%h v=%b h=%b",
                 e.name, bus.pc, bus.ins, bus.ins_valid, bus.halted, e.pc, e.ins, e.v, e.h);
      end else begin
        $display("ok   %s: pc=%h ins=%h v=%b h=%b", e.name, bus.pc, bus.ins, bus.ins_valid, bus.halted);
      end
    end
  end

  task automatic step(input string name, input logic s, input logic sp,
                      input logic [7:0] epc, input logic [23:0] eins,
                      input logic ev, input logic eh);
    sb_t e;
    bus.stall    = s;
    bus.stall_pm = sp;
    e.cyc  = cyc + 1;
    e.name = name;
    e.pc   = epc;
    e.ins  = eins;
    e.v    = ev;
    e.h    = eh;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic check_now(input string name, input logic [7:0] epc, input logic [23:0] eins,
                           input logic ev, input logic eh);
    checks++;
    if (bus.pc !== epc || bus.ins !== eins || bus.ins_valid !== ev || bus.halted !== eh) begin
      errors++;
      $display("FAIL %s: got pc=%h ins=%h v=%b h=%b, expected pc=%h ins=%h v=%b h=%b",
               name, bus.pc, bus.ins, bus.ins_valid, bus.halted, epc, eins, ev, eh);
    end else begin
      $display("ok   %s: pc=%h ins=%h v=%b h=%b", name, bus.pc, bus.ins, bus.ins_valid, bus.halted);
    end
  endtask

  initial begin
    #100000;
    errors++;
    checks++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    for (int i = 0; i < 256; i++) mem[i] = 24'h100001 + i;
    mem[5]     = 24'hE00020;
    mem[6]     = 24'h880000;
    mem[8'h21] = 24'h880000;
    reset = 1'b0;
    bus.stall = 1'b0;
    bus.stall_pm = 1'b0;
    #2;
    check_now("reset_state", 8'h00, 24'h000000, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Straight-line fetch and stall hold
    step("fetch0", 0, 0, 8'h01, 24'h100001, 1, 0);
    step("fetch1", 0, 0, 8'h02, 24'h100002, 1, 0);
    for (int i = 0; i < 3; i++) step("stall_hold", 1, 0, 8'h02, 24'h100002, 1, 0);
    step("resume", 0, 0, 8'h03, 24'h100003, 1, 0);
    step("bubble", 0, 1, 8'h03, 24'h000000, 0, 0);
    step("after_bubble", 0, 0, 8'h04, 24'h100004, 1, 0);
    step("fetch4", 0, 0, 8'h05, 24'h100005, 1, 0);
    step("fetch_jump", 0, 0, 8'h06, 24'hE00020, 1, 0);
    step("jump_over_stall", 1, 0, 8'h20, 24'h000000, 0, 0);
    step("jump_target", 0, 0, 8'h21, 24'h100021, 1, 0);
    step("fetch_hlt", 0, 0, 8'h22, 24'h880000, 1, 0);
    step("halt_enter", 0, 0, 8'h22, 24'h880000, 1, 1);
    for (int i = 0; i < 20; i++) begin
      logic [1:0] t;
      t = i[1:0];
      step("halt_frozen", t[0], t[1], 8'h22, 24'h880000, 1, 1);
    end

`ifdef FETCH_PERF_EN
    checks++;
    if (stall_cnt !== 16'd4) begin
      errors++;
      $display("FAIL stall_cnt: got %0d, expected 4", stall_cnt);
    end else $display("ok   stall_cnt: %0d", stall_cnt);
`endif

    // Reset pulse out of HALT, applied between edges
    @(negedge clk);
    #1;
    bus.stall = 1'b0;
    bus.stall_pm = 1'b0;
    reset = 1'b0;
    #1;
    check_now("reset_from_halt_async", 8'h00, 24'h000000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_now("reset_held", 8'h00, 24'h000000, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // Wrap: jump to FF then fetch wraps pc to 00
    mem[0] = 24'hE000FF;
    step("fetch_jump_ff", 0, 0, 8'h01, 24'hE000FF, 1, 0);
    step("jump_ff", 0, 0, 8'hFF, 24'h000000, 0, 0);
    step("wrap", 0, 0, 8'h00, 24'h100100, 1, 0);
    step("after_wrap", 0, 0, 8'h01, 24'hE000FF, 1, 0);
    step("jump_over_both", 1, 1, 8'hFF, 24'h000000, 0, 0);

    // Async reset mid-jump; the first fetch afterwards reads address 0
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_now("reset_mid_jump_async", 8'h00, 24'h000000, 1'b0, 1'b0);
`ifdef FETCH_PERF_EN
    checks++;
    if (stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL stall_cnt_reset: got %0d, expected 0", stall_cnt);
    end else $display("ok   stall_cnt_reset: %0d", stall_cnt);
`endif
    @(negedge clk);
    reset = 1'b1;
    step("first_after_reset", 1'b0, 1'b0, 8'h01, 24'hE000FF, 1, 0);

    repeat (3) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
